sseg_capture_decoder: RTL

Monitor-side decoder for a multiplexed 7-segment display bus. It samples the segment lines and one-hot digit strobes, waits until they have been stable for a set number of cycles, and decodes each captured pattern back to a hex nibble. It also keeps a per-digit register file of the recovered value. It sits beside the display driver and serves on-board self-check and bench readback of what the matrix accelerator is displaying.

---
 rtl/sseg_capture_decoder.sv | 138 +++++++++++++
 1 files changed

// File: rtl/sseg_capture_decoder.sv
// sseg_capture_decoder
// Watches a multiplexed 7-segment bus (segments + one-hot digit strobes),
// waits for the sampled bus to be stable for STABLE_CYCLES samples, then
// decodes the glyph back to a hex nibble into a per-digit register file.
module sseg_capture_decoder #(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              sseg,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic                    clr,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    update,
  output logic [2:0]              update_idx,
  output logic                    bad_pattern,
  output logic                    an_error
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] LOCKED = 2'd2;

  localparam logic [7:0] CNT_MAX = 8'(STABLE_CYCLES);

  logic [6:0]            s_seg;
  logic [NUM_DIGITS-1:0] s_an;
  logic [7:0]            cnt;
  logic [1:0]            state;

  logic                  changed;
  logic                  capture;
  logic                  an_multi;
  logic [2:0]            hit_idx;
  logic [4:0]            glyph;

  // {legal, nibble} for a segment pattern; illegal patterns return legal = 0
  function automatic logic [4:0] decode(input logic [6:0] p);
    logic [4:0] r;
    case (p)
      7'h7E:   r = 5'h10;
      7'h30:   r = 5'h11;
      7'h6D:   r = 5'h12;
      7'h79:   r = 5'h13;
      7'h33:   r = 5'h14;
      7'h5B:   r = 5'h15;
      7'h5F:   r = 5'h16;
      7'h70:   r = 5'h17;
      7'h7F:   r = 5'h18;
      7'h7B:   r = 5'h19;
      7'h7D:   r = 5'h1A;
      7'h1F:   r = 5'h1B;
      7'h4E:   r = 5'h1C;
      7'h3D:   r = 5'h1D;
      7'h4F:   r = 5'h1E;
      7'h47:   r = 5'h1F;
      default: r = 5'h00;
    endcase
    return r;
  endfunction

  // Change detection compares the word about to be sampled with the held
  // sample, so the count restarts on the same edge the new value lands.
  assign changed  = {sseg, an} != {s_seg, s_an};
  assign capture  = (state == TRACK) && (cnt == CNT_MAX);
  assign an_multi = (s_an & (s_an - NUM_DIGITS'(1))) != '0;
  assign glyph    = decode(s_seg);

  // Index of the strobed digit (only used when s_an is one-hot)
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++)
      if (s_an[i]) hit_idx = 3'(i);
  end

  // Input sampling and saturating stability counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_seg <= '0;
      s_an  <= '0;
      cnt   <= '0;
    end else begin
      s_seg <= sseg;
      s_an  <= an;
      if (changed)             cnt <= 8'd1;
      else if (cnt != CNT_MAX) cnt <= cnt + 8'd1;
    end
  end

  // Capture FSM: one capture per stable strobe interval; clr has no effect here
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else if (changed) begin
      state <= (an == '0) ? IDLE : TRACK;
    end else if (capture) begin
      state <= LOCKED;
    end
  end

  // Digit register file and one-cycle status pulses; clr overrides a capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      digits      <= '0;
      digit_valid <= '0;
      update      <= 1'b0;
      update_idx  <= '0;
      bad_pattern <= 1'b0;
      an_error    <= 1'b0;
    end else begin
      update      <= 1'b0;
      bad_pattern <= 1'b0;
      an_error    <= 1'b0;
      if (clr) begin
        digit_valid <= '0;
      end else if (capture) begin
        if (an_multi) begin
          an_error <= 1'b1;
        end else if (glyph[4]) begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (s_an[i]) begin
              digits[4*i +: 4] <= glyph[3:0];
              digit_valid[i]   <= 1'b1;
            end
          update     <= 1'b1;
          update_idx <= hit_idx;
        end else begin
          for (int i = 0; i < NUM_DIGITS; i++)
            if (s_an[i]) digit_valid[i] <= 1'b0;
          bad_pattern <= 1'b1;
        end
      end
    end
  end

endmodule
